// File: rtl/cap_mem_access_seq.sv
// rtl/cap_mem_access_seq.sv - capability/word memory access sequencer with shadow tag array
module cap_mem_access_seq #(
    parameter int TAG_ENTRIES = 64,
    parameter int TAG_IDX_W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic         req_is_cap,
    input  logic [31:0]  req_addr,
    input  logic [128:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [128:0] resp_rdata,
    output logic         resp_err,
    output logic         MemRead,
    output logic         MemWrite,
    output logic [31:0]  MemAddr,
    output logic [128:0] MemWd,
    input  logic [128:0] MemRd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [1:0]             r_beat;
    logic [31:0]            r_addr;
    logic                   r_write;
    logic                   r_cap;
    logic [128:0]           r_wdata;
    logic [128:0]           r_rdata;
    logic                   r_err;
    logic [TAG_ENTRIES-1:0] r_tag;

    logic                   w_misaligned;
    logic                   w_last_beat;
    logic [TAG_IDX_W-1:0]   w_tag_idx;
    logic [6:0]             w_lane_lsb;
    logic [31:0]            w_beat_word;
    logic [31:0]            w_beat_addr;
    logic                   w_unused_memrd;

    assign w_misaligned   = req_is_cap ? (req_addr[3:0] != 4'd0) : (req_addr[1:0] != 2'd0);
    assign w_last_beat    = r_cap ? (r_beat == 2'd3) : (r_beat == 2'd0);
    // Tags alias modulo TAG_ENTRIES granules of 16 bytes.
    assign w_tag_idx      = r_addr[4+TAG_IDX_W-1:4];
    assign w_lane_lsb     = {r_beat, 5'd0};
    assign w_beat_word    = r_wdata[w_lane_lsb +: 32];
    assign w_beat_addr    = r_addr + {28'd0, r_beat, 2'b00};
    // The memory is 32 bits wide; the upper read lanes carry nothing meaningful.
    assign w_unused_memrd = ^MemRd[128:32];

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake/memory strobes; strobes only live in BEAT.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemAddr      = 32'd0;
        MemWd        = 129'd0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_misaligned ? S_RESP : S_BEAT;
                end
            end
            S_BEAT: begin
                MemRead  = !r_write;
                MemWrite = r_write;
                MemAddr  = w_beat_addr;
                MemWd    = {97'd0, w_beat_word};
                if (w_last_beat) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, beat counter, read-data assembly and shadow tag updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= 2'd0;
            r_addr  <= 32'd0;
            r_write <= 1'b0;
            r_cap   <= 1'b0;
            r_wdata <= 129'd0;
            r_rdata <= 129'd0;
            r_err   <= 1'b0;
            r_tag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_cap   <= req_is_cap;
                        r_wdata <= req_wdata;
                        r_beat  <= 2'd0;
                        r_rdata <= 129'd0;
                        r_err   <= w_misaligned;
                    end
                end
                S_BEAT: begin
                    if (!r_write) begin
                        r_rdata[w_lane_lsb +: 32] <= MemRd[31:0];
                    end
                    if (w_last_beat) begin
                        if (r_write) begin
                            // A word store partially overwrites a granule, so it kills the tag.
                            r_tag[w_tag_idx] <= r_cap ? r_wdata[128] : 1'b0;
                        end else if (r_cap) begin
                            r_rdata[128] <= r_tag[w_tag_idx];
                        end
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
